// File: rtl/cfg_serial_loader.sv
// Serial configuration loader for the dual XOR stream cipher core.
// Shifts a parallel word into the core scan chain LSB first and captures the old chain.
module cfg_serial_loader #(
    parameter int M      = 32,
    parameter int SETTLE = 2,
    localparam int W     = 2*M+2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] cfg_data,
    output logic         cfg_en,
    output logic         cfg_i,
    input  logic         cfg_o,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] rb_data,
    output logic         run_en
);

    localparam int CW = $clog2(W);
    localparam int SW = $clog2(SETTLE+1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_SETTLE,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    sreg_q, sreg_d;
    logic [W-1:0]    rb_sh_q, rb_sh_d;
    logic [W-1:0]    rb_data_q, rb_data_d;
    logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [SW-1:0]   set_cnt_q, set_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sreg_q    <= '0;
            rb_sh_q   <= '0;
            rb_data_q <= '0;
            bit_cnt_q <= '0;
            set_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            rb_sh_q   <= rb_sh_d;
            rb_data_q <= rb_data_d;
            bit_cnt_q <= bit_cnt_d;
            set_cnt_q <= set_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        rb_sh_d   = rb_sh_q;
        rb_data_d = rb_data_q;
        bit_cnt_d = bit_cnt_q;
        set_cnt_d = set_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    sreg_d    = cfg_data;
                    bit_cnt_d = '0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Readback enters at the top so core bit 0 ends up in rb_sh[0]
                sreg_d    = {1'b0, sreg_q[W-1:1]};
                rb_sh_d   = {cfg_o, rb_sh_q[W-1:1]};
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == CW'(W-1)) begin
                    set_cnt_d = '0;
                    state_d   = S_SETTLE;
                end
            end
            S_SETTLE: begin
                set_cnt_d = set_cnt_q + 1'b1;
                if (set_cnt_q == SW'(SETTLE-1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                rb_data_d = rb_sh_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cfg_en  = (state_q == S_SHIFT);
    assign cfg_i   = cfg_en & sreg_q[0];
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign run_en  = ~busy;
    assign rb_data = rb_data_q;

endmodule
